sm_bus_arbiter: RTL



---
 rtl/sm_bus_arbiter_pkg.sv | 19 +
 rtl/sm_arb_rr.sv | 12 +
 rtl/sm_bus_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/sm_bus_arbiter_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package sm_bus_arbiter_pkg;
  localparam int NUM_MASTERS        = 2;
  localparam int ADDR_W             = 32;
  localparam int DATA_W             = 32;
  localparam int SM_ARB_WAIT_CYCLES = 0;

  typedef enum logic [1:0] {
    SM_ARB_IDLE  = 2'd0,
    SM_ARB_GRANT = 2'd1,
    SM_ARB_RESP  = 2'd2
  } arbState_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wData;
  } busReq_t;
endpackage

// File: rtl/sm_arb_rr.sv
// Combinational 2-way round-robin picker: on a tie the master not granted last wins.
module sm_arb_rr (
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic       grantIdx,
  output logic       anyReq
);
  always_comb begin
    anyReq   = |req;
    grantIdx = (req == 2'b11) ? ~lastGrant : req[1];
  end
endmodule

// File: rtl/sm_bus_arbiter.sv
// Shares the sm_matrix data bus between two request/ack masters, one transaction
// at a time, round-robin on ties, with WAIT_CYCLES slave wait states.
module sm_bus_arbiter
  import sm_bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = SM_ARB_WAIT_CYCLES,
  parameter bit PRIO_RESET  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0Req,
  input  logic [ADDR_W-1:0] m0Addr,
  input  logic              m0We,
  input  logic [DATA_W-1:0] m0WData,
  output logic              m0Ack,
  output logic [DATA_W-1:0] m0RData,
  input  logic              m1Req,
  input  logic [ADDR_W-1:0] m1Addr,
  input  logic              m1We,
  input  logic [DATA_W-1:0] m1WData,
  output logic              m1Ack,
  output logic [DATA_W-1:0] m1RData,
  output logic [ADDR_W-1:0] bAddr,
  output logic              bWe,
  output logic [DATA_W-1:0] bWData,
  input  logic [DATA_W-1:0] bRData
);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gBadWait
    $error("sm_bus_arbiter: WAIT_CYCLES must be 0..15");
  end

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  arbState_t                              state;
  logic [3:0]                             waitCnt;
  logic                                   owner, lastGrant;
  logic                                   grantIdx, anyReq;
  logic [NUM_MASTERS-1:0]                 ack;
  logic [NUM_MASTERS-1:0][DATA_W-1:0]     rData;
  busReq_t [NUM_MASTERS-1:0]              mReq;

  assign mReq[0] = '{addr: m0Addr, we: m0We, wData: m0WData};
  assign mReq[1] = '{addr: m1Addr, we: m1We, wData: m1WData};

  sm_arb_rr uRr (
    .req      ({m1Req, m0Req}),
    .lastGrant(lastGrant),
    .grantIdx (grantIdx),
    .anyReq   (anyReq)
  );

  // Bus outputs are registered; the write strobe is set one edge ahead so it
  // is high only in the cycle where waitCnt == WAIT_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SM_ARB_IDLE;
      waitCnt   <= '0;
      owner     <= 1'b0;
      lastGrant <= ~PRIO_RESET;
      ack       <= '0;
      rData     <= '0;
      bAddr     <= '0;
      bWe       <= 1'b0;
      bWData    <= '0;
    end else begin
      case (state)
        SM_ARB_IDLE: begin
          if (anyReq) begin
            owner   <= grantIdx;
            waitCnt <= '0;
            bAddr   <= mReq[grantIdx].addr;
            bWData  <= mReq[grantIdx].wData;
            bWe     <= (WAIT_LAST == 4'd0) & mReq[grantIdx].we;
            state   <= SM_ARB_GRANT;
          end
        end
        SM_ARB_GRANT: begin
          if (waitCnt == WAIT_LAST) begin
            rData[owner] <= bRData;
            ack[owner]   <= 1'b1;
            lastGrant    <= owner;
            waitCnt      <= '0;
            bAddr        <= '0;
            bWData       <= '0;
            bWe          <= 1'b0;
            state        <= SM_ARB_RESP;
          end else begin
            waitCnt <= waitCnt + 4'd1;
            bWe     <= ((waitCnt + 4'd1) == WAIT_LAST) & mReq[owner].we;
          end
        end
        SM_ARB_RESP: begin
          ack   <= '0;
          state <= SM_ARB_IDLE;
        end
        default: state <= SM_ARB_IDLE;
      endcase
    end
  end

  assign m0Ack   = ack[0];
  assign m1Ack   = ack[1];
  assign m0RData = rData[0];
  assign m1RData = rData[1];
endmodule
